// File: rtl/exec_muldiv_unit_pkg.sv
// Shared constants for the RV32M execute-stage multiply/divide unit and the decoder.
package exec_muldiv_unit_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic fn_signed_a(input logic [2:0] fn);
    return (fn == FN_MULH) || (fn == FN_MULHSU) || (fn == FN_DIV) || (fn == FN_REM);
  endfunction

  function automatic logic fn_signed_b(input logic [2:0] fn);
    return (fn == FN_MULH) || (fn == FN_DIV) || (fn == FN_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate of a hi/lo pair (split or as one 2W value) plus hi/lo select.
module muldiv_signfix
  import exec_muldiv_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic         neg_hi_i,
  input  logic         neg_lo_i,
  input  logic         wide_i,
  input  logic         sel_hi_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] res_o
);

  logic [2*W-1:0] wide_neg_s;

  // wide_i negates {hi,lo} as a single product; otherwise each half uses its own flag
  always_comb begin
    wide_neg_s = -{hi_i, lo_i};
    if (wide_i) begin
      {hi_o, lo_o} = neg_lo_i ? wide_neg_s : {hi_i, lo_i};
    end else begin
      hi_o = neg_hi_i ? -hi_i : hi_i;
      lo_o = neg_lo_i ? -lo_i : lo_i;
    end
    res_o = sel_hi_i ? hi_o : lo_o;
  end

endmodule

// File: rtl/exec_muldiv_unit.sv
// RV32M iterative multiply/divide unit with pipeline stall; MULDIV_FAST_MUL_EN selects a one-shot multiplier.
module exec_muldiv_unit
  import exec_muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            md_req,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic            md_busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2:0]        fn_q, fn_d;
  logic              neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic            sgn_a_s, sgn_b_s, div_zero_s, div_ovf_s, sel_hi_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s, entry_unused_s, exit_hi_s, exit_lo_s, exit_res_s;
  logic [XLEN:0]   mul_sum_s, div_diff_s;
  logic [2*XLEN-1:0] mul_step_s, div_step_s;

  assign sgn_a_s    = fn_signed_a(funct3) & op_a[XLEN-1];
  assign sgn_b_s    = fn_signed_b(funct3) & op_b[XLEN-1];
  assign div_zero_s = funct3[2] & (op_b == {XLEN{1'b0}});
  assign div_ovf_s  = ((funct3 == FN_DIV) || (funct3 == FN_REM)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});

  muldiv_signfix #(.W(XLEN)) u_entry (
    .hi_i(op_b), .lo_i(op_a), .neg_hi_i(sgn_b_s), .neg_lo_i(sgn_a_s),
    .wide_i(1'b0), .sel_hi_i(1'b0),
    .hi_o(mag_b_s), .lo_o(mag_a_s), .res_o(entry_unused_s)
  );

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend->quotient}
  assign mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  assign mul_step_s = {mul_sum_s, acc_q[XLEN-1:1]};
  assign div_diff_s = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
  assign div_step_s = {div_diff_s[XLEN] ? acc_q[2*XLEN-2:XLEN-1] : div_diff_s[XLEN-1:0],
                       acc_q[XLEN-2:0], ~div_diff_s[XLEN]};

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a_s, fast_b_s, fast_p_s;
  // 33-bit signed operands (unsigned ones get a zero top bit), sign-extended to the product width
  assign fast_a_s = {{XLEN{sgn_a_s}}, op_a};
  assign fast_b_s = {{XLEN{sgn_b_s}}, op_b};
  assign fast_p_s = fast_a_s * fast_b_s;
`endif

  // FSM and datapath next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    fn_d     = fn_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_req && !flush) begin
          fn_d     = funct3;
          cnt_d    = {CNT_W{1'b0}};
          neg_hi_d = funct3[2] & sgn_a_s;
          neg_lo_d = sgn_a_s ^ sgn_b_s;
          if (div_zero_s) begin
            acc_d    = {op_a, {XLEN{1'b1}}};
            neg_hi_d = 1'b0;
            neg_lo_d = 1'b0;
            state_d  = ST_DONE;
          end else if (div_ovf_s) begin
            acc_d    = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            neg_hi_d = 1'b0;
            neg_lo_d = 1'b0;
            state_d  = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!funct3[2]) begin
            acc_d    = fast_p_s;
            neg_hi_d = 1'b0;
            neg_lo_d = 1'b0;
            state_d  = ST_DONE;
`endif
          end else begin
            mcand_d = funct3[2] ? mag_b_s : mag_a_s;
            acc_d   = {{XLEN{1'b0}}, funct3[2] ? mag_a_s : mag_b_s};
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = fn_q[2] ? div_step_s : mul_step_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  assign sel_hi_s = fn_d[2] ? fn_d[1] : (fn_d[1:0] != 2'b00);

  muldiv_signfix #(.W(XLEN)) u_exit (
    .hi_i(acc_d[2*XLEN-1:XLEN]), .lo_i(acc_d[XLEN-1:0]),
    .neg_hi_i(neg_hi_d), .neg_lo_i(neg_lo_d),
    .wide_i(~fn_d[2]), .sel_hi_i(sel_hi_s),
    .hi_o(exit_hi_s), .lo_o(exit_lo_s), .res_o(exit_res_s)
  );

  // Result is captured only on the transition into DONE
  always_comb begin
    done_d = (state_d == ST_DONE);
    if (done_d) begin
      result_d = exit_res_s;
    end else begin
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      mcand_q  <= {XLEN{1'b0}};
      fn_q     <= 3'b000;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      result_q <= {XLEN{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      fn_q     <= fn_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign md_done   = done_q;
  assign md_result = result_q;
  assign md_busy   = (state_q != ST_IDLE);
  assign md_stall  = md_req & ~done_q & ~flush;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Scoreboard bench for exec_muldiv_unit: latency, results, stall, flush, reset and back-to-back ops.
module tb_exec_muldiv_unit;
  import exec_muldiv_unit_pkg::*;

  localparam int XLEN = 32;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        md_req;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        md_stall;
  logic        md_done;
  logic [31:0] md_result;
  logic        md_busy;

  int          checks;
  int          errors;
  logic [31:0] sb_q[$];
  logic [31:0] last_res;
  time         done_t;

  exec_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .md_req(md_req),
    .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .md_stall(md_stall), .md_done(md_done), .md_result(md_result), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_md(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (fn)
      FN_MUL:    begin p = ua * ub; return p[31:0]; end
      FN_MULH:   begin p = sa * sb; return p[63:32]; end
      FN_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      FN_MULHU:  begin p = ua * ub; return p[63:32]; end
      FN_DIV:    begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (ovf) return 32'h80000000;
        sq = sa / sb; return sq[31:0];
      end
      FN_DIVU:   return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      FN_REM:    begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        sq = sa % sb; return sq[31:0];
      end
      default:   return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    if (fn[2] && ((b == 32'd0) ||
        (((fn == FN_DIV) || (fn == FN_REM)) && (a == 32'h80000000) && (b == 32'hFFFFFFFF))))
      return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!fn[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input string name);
    int          cyc;
    int          lat;
    bit          seen;
    bit          stall_bad;
    logic [31:0] e;
    lat = exp_lat(fn, a, b);
    @(negedge clk);
    md_req = 1'b1; funct3 = fn; op_a = a; op_b = b;
    sb_q.push_back(ref_md(fn, a, b));
    #1;
    checks++;
    if (md_done !== 1'b0 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: done=%b busy=%b, required 0 0", name, md_done, md_busy);
    end
    cyc = 0; seen = 1'b0; stall_bad = 1'b0;
    while (!seen && cyc <= 100) begin
      if (md_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (md_stall !== 1'b1) stall_bad = 1'b1;
        @(negedge clk); #1;
        cyc++;
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no md_done within %0d cycles, required at cycle %0d", name, cyc, lat);
    end else begin
      if (cyc != lat) begin
        errors++;
        $display("FAIL %s_latency: md_done at cycle %0d, required %0d", name, cyc, lat);
      end
      checks++;
      if (md_result !== e) begin
        errors++;
        $display("FAIL %s_result: got %h, required %h", name, md_result, e);
      end
      checks++;
      if (stall_bad || md_stall !== 1'b0) begin
        errors++;
        $display("FAIL %s_stall: stall_dropped_early=%b stall_at_done=%b, required 0 0", name, stall_bad, md_stall);
      end
      done_t   = $time;
      last_res = e;
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    md_req = 1'b0; #1;
    checks++;
    if (md_stall !== 1'b0 || md_busy !== 1'b0 || md_done !== 1'b0) begin
      errors++;
      $display("FAIL idle: stall=%b busy=%b done=%b, required 0 0 0", md_stall, md_busy, md_done);
    end
    repeat (n) @(negedge clk);
    #1;
    checks++;
    if (md_result !== last_res || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: result=%h busy=%b, required %h 0", md_result, md_busy, last_res);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; flush = 1'b0; md_req = 1'b0; funct3 = 3'b000; op_a = 32'd0; op_b = 32'd0;
    last_res = 32'd0;
    #1;
    checks++;
    if (md_done !== 1'b0 || md_busy !== 1'b0 || md_stall !== 1'b0 || md_result !== 32'd0) begin
      errors++;
      $display("FAIL reset: done=%b busy=%b stall=%b result=%h, required all 0", md_done, md_busy, md_stall, md_result);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mul;
    run_op(FN_MUL,    32'd7,        32'hFFFFFFFD, "mul_7_m3");
    go_idle(2);
    run_op(FN_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");
    run_op(FN_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, "mulh");
    run_op(FN_MULHSU, 32'hFFFFFFFF, 32'd2,        "mulhsu");
    go_idle(1);
  endtask

  task automatic test_div;
    run_op(FN_DIV,  32'hFFFFFFF9, 32'd2,        "div_m7_2");
    run_op(FN_REM,  32'hFFFFFFF9, 32'd2,        "rem_m7_2");
    run_op(FN_DIVU, 32'd100,      32'd7,        "divu_100_7");
    run_op(FN_REMU, 32'd100,      32'd7,        "remu_100_7");
    go_idle(1);
  endtask

  task automatic test_special;
    run_op(FN_DIV, 32'd5,        32'd0,        "div_by_zero");
    run_op(FN_REM, 32'd5,        32'd0,        "rem_by_zero");
    run_op(FN_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(FN_REM, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
    go_idle(1);
  endtask

  task automatic test_flush;
    bit saw_done;
    @(negedge clk);
    md_req = 1'b1; funct3 = FN_DIV; op_a = 32'd1000; op_b = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1; #1;
    checks++;
    if (md_stall !== 1'b0 || md_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle: stall=%b busy=%b, required 0 1", md_stall, md_busy);
    end
    @(negedge clk);
    flush = 1'b0; md_req = 1'b0; #1;
    checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b done=%b, required 0 0", md_busy, md_done);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (md_done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || md_result !== last_res) begin
      errors++;
      $display("FAIL flush_no_done: saw_done=%b result=%h, required 0 %h", saw_done, md_result, last_res);
    end
    run_op(FN_DIVU, 32'd9, 32'd3, "divu_after_flush");
    go_idle(1);
  endtask

  task automatic test_reset_mid_calc;
    @(negedge clk);
    md_req = 1'b1; funct3 = FN_MUL; op_a = 32'd123; op_b = 32'd456;
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0; md_req = 1'b0;
    #1;
    checks++;
    if (md_done !== 1'b0 || md_busy !== 1'b0 || md_stall !== 1'b0 || md_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: done=%b busy=%b stall=%b result=%h, required all 0", md_done, md_busy, md_stall, md_result);
    end
    last_res = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(FN_MUL, 32'd123, 32'd456, "mul_after_reset");
    go_idle(1);
  endtask

  task automatic test_back_to_back;
    time t1;
    run_op(FN_MUL, 32'd1234, 32'd5678, "b2b_first");
    t1 = done_t;
    run_op(FN_MUL, 32'hFFFFFF00, 32'd77, "b2b_second");
    checks++;
    if (done_t - t1 != 340) begin
      errors++;
      $display("FAIL b2b_spacing: %0t between md_done pulses, required 340", done_t - t1);
    end
    go_idle(1);
  endtask

  task automatic test_random;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) begin
      fn = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(fn, a, b, "random");
    end
    go_idle(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
